pipe_stage_skid: RTL and testbench

- Parametrised, flow-controlled successor to the fixed-width ID/EX and EX/MEM pipeline buffers.
- Sits between two pipeline stages and registers a `{control, payload}` word.
- Supports a ready/valid stall, a synchronous flush and bubble insertion (control field zeroed when empty).
- A 2-entry skid keeps `in_ready` purely registered, so no combinational ready path crosses stages.

---
 rtl/pipe_stage_skid.sv | 139 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Flow-controlled pipeline register with a 2-entry skid, so in_ready comes straight from a flop.
// The control field is cleared whenever the stage holds no live word (bubble / flush).
module pipe_stage_skid #(
  parameter int WIDTH                  = 37,
  parameter int CTRL_WIDTH             = 5,
  parameter int PASS_PAYLOAD_ON_BUBBLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       occupancy
);

  localparam int PW = WIDTH - CTRL_WIDTH;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic [1:0]       occupancy_q, occupancy_d;
  logic             in_fire_s;
  logic             out_fire_s;

  // A word with its control field cleared; payload kept or zeroed by parameter.
  function automatic logic [WIDTH-1:0] bubble_word(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] r;
    r = '0;
    if (PASS_PAYLOAD_ON_BUBBLE != 0) begin
      r[PW-1:0] = w[PW-1:0];
    end else begin
      r = '0;
    end
    return r;
  endfunction

  assign in_fire_s  = in_valid & in_ready_q;
  assign out_fire_s = out_valid_q & out_ready;

  // Next-state and storage update; flush overrides every handshake.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = bubble_word(main_q);
      skid_d  = bubble_word(skid_q);
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire_s) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_fire_s && out_fire_s) begin
            main_d = in_data;
          end else if (in_fire_s) begin
            state_d = ST_TWO;
            skid_d  = in_data;
          end else if (out_fire_s) begin
            state_d = ST_EMPTY;
            main_d  = bubble_word(main_q);
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_TWO: begin
          // Skid always drains into main before any newer word can enter.
          if (out_fire_s) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            skid_d  = bubble_word(skid_q);
          end else begin
            state_d = ST_TWO;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = bubble_word(main_q);
          skid_d  = bubble_word(skid_q);
        end
      endcase
    end
  end

  // Status outputs decoded from the next state so they leave the stage as flops.
  always_comb begin
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_TWO);
    case (state_d)
      ST_EMPTY: occupancy_d = 2'd0;
      ST_ONE:   occupancy_d = 2'd1;
      ST_TWO:   occupancy_d = 2'd2;
      default:  occupancy_d = 2'd0;
    endcase
  end

  // State, storage and registered status flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      occupancy_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      occupancy_q <= occupancy_d;
    end
  end

  assign out_data  = main_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign occupancy = occupancy_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed checks of pipe_stage_skid (default format, both bubble payload modes) plus
// a randomized EX/MEM-format run against a depth-2 FIFO reference.
module tb_pipe_stage_skid;

  logic        clk;
  logic        rst_n;
  logic        in_valid, out_ready, flush;
  logic [36:0] in_data;
  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [36:0] a_out_data, b_out_data;
  logic [1:0]  a_occ, b_occ;

  logic        c_in_valid, c_out_ready, c_flush, c_in_ready, c_out_valid;
  logic [66:0] c_in_data, c_out_data;
  logic [1:0]  c_occ;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_stage_skid #(.WIDTH(37), .CTRL_WIDTH(5), .PASS_PAYLOAD_ON_BUBBLE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data), .flush(flush),
    .occupancy(a_occ));

  pipe_stage_skid #(.WIDTH(37), .CTRL_WIDTH(5), .PASS_PAYLOAD_ON_BUBBLE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data), .flush(flush),
    .occupancy(b_occ));

  pipe_stage_skid #(.WIDTH(67), .CTRL_WIDTH(3), .PASS_PAYLOAD_ON_BUBBLE(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data), .flush(c_flush),
    .occupancy(c_occ));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [36:0] mk(input logic [4:0] c);
    return {c, 16'd11, 16'd15};
  endfunction

  logic [36:0] w [5];
  logic [36:0] bub_a;
  logic [66:0] mq [$];
  logic        in_fire_m, out_fire_m;

  initial begin
    w[0] = mk(5'b10010); w[1] = mk(5'b10011); w[2] = mk(5'b00000);
    w[3] = mk(5'b10100); w[4] = mk(5'b11000);
    bub_a = {5'b00000, 16'd11, 16'd15};
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0; in_data = 37'd0;
    c_in_valid = 1'b0; c_out_ready = 1'b0; c_flush = 1'b0; c_in_data = 67'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst_in_ready", 128'(a_in_ready), 128'(1'b1));
    chk("rst_out_valid", 128'(a_out_valid), 128'(1'b0));
    chk("rst_occ", 128'(a_occ), 128'(2'd0));
    chk("rst_out_data", 128'(a_out_data), 128'(37'd0));

    // Load a word, stall, then assert reset mid-cycle and check before any edge.
    in_valid = 1'b1; in_data = w[1]; out_ready = 1'b0; tick();
    in_valid = 1'b0; tick();
    chk("pre_rst_valid", 128'(a_out_valid), 128'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 128'(a_out_valid), 128'(1'b0));
    chk("async_rst_data", 128'(a_out_data), 128'(37'd0));
    chk("async_rst_ready", 128'(a_in_ready), 128'(1'b1));
    chk("async_rst_occ", 128'(a_occ), 128'(2'd0));
    #2 rst_n = 1'b1;

    in_valid = 1'b1; in_data = w[0]; out_ready = 1'b1; tick();
    chk("flow_valid", 128'(a_out_valid), 128'(1'b1));
    chk("flow_data", 128'(a_out_data), 128'(w[0]));
    chk("flow_occ", 128'(a_occ), 128'(2'd1));

    for (int i = 0; i < 5; i++) begin
      in_data = w[i]; tick();
      chk("stream_data", 128'(a_out_data), 128'(w[i]));
      chk("stream_valid", 128'(a_out_valid), 128'(1'b1));
      chk("stream_ready", 128'(a_in_ready), 128'(1'b1));
    end
    in_valid = 1'b0; tick();
    chk("drain_valid", 128'(a_out_valid), 128'(1'b0));
    chk("bubble_keep_payload", 128'(a_out_data), 128'(bub_a));
    chk("bubble_zero_payload", 128'(b_out_data), 128'(37'd0));

    // Stall and skid: W0 stalls in main, W1 lands in skid, W2 waits upstream.
    in_valid = 1'b1; in_data = w[1]; tick();
    out_ready = 1'b0; in_data = w[3]; tick();
    chk("skid_occ", 128'(a_occ), 128'(2'd2));
    chk("skid_in_ready", 128'(a_in_ready), 128'(1'b0));
    chk("skid_data_w0", 128'(a_out_data), 128'(w[1]));
    in_data = w[4]; tick();
    chk("stall_data_stable", 128'(a_out_data), 128'(w[1]));
    chk("stall_occ", 128'(a_occ), 128'(2'd2));
    out_ready = 1'b1; tick();
    chk("unstall_data_w1", 128'(a_out_data), 128'(w[3]));
    chk("unstall_occ", 128'(a_occ), 128'(2'd1));
    chk("unstall_ready", 128'(a_in_ready), 128'(1'b1));
    tick();
    chk("order_w2", 128'(a_out_data), 128'(w[4]));
    in_valid = 1'b0; tick();
    chk("stall_drain_valid", 128'(a_out_valid), 128'(1'b0));

    // Flush with a full buffer and a simultaneous incoming word.
    out_ready = 1'b0; in_valid = 1'b1; in_data = w[0]; tick();
    in_data = w[1]; tick();
    chk("pre_flush_occ", 128'(a_occ), 128'(2'd2));
    flush = 1'b1; in_data = w[4]; tick();
    chk("flush_valid", 128'(a_out_valid), 128'(1'b0));
    chk("flush_ctrl", 128'(a_out_data[36:32]), 128'(5'd0));
    chk("flush_occ", 128'(a_occ), 128'(2'd0));
    chk("flush_ready", 128'(a_in_ready), 128'(1'b1));
    chk("flush_payload_a", 128'(a_out_data), 128'(bub_a));
    chk("flush_payload_b", 128'(b_out_data), 128'(37'd0));
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; tick();
    chk("flush_input_dropped", 128'(a_out_valid), 128'(1'b0));
    chk("flush_input_occ", 128'(a_occ), 128'(2'd0));

    // Random traffic on the 67/3 instance against a depth-2 FIFO reference.
    for (int k = 0; k < 400; k++) begin
      c_in_valid  = ($urandom_range(0, 3) != 0);
      c_out_ready = ($urandom_range(0, 2) != 0);
      c_flush     = ($urandom_range(0, 29) == 0);
      c_in_data   = {3'($urandom()), $urandom(), $urandom()};
      in_fire_m   = c_in_valid && (mq.size() < 2);
      out_fire_m  = (mq.size() > 0) && c_out_ready;
      tick();
      if (c_flush) begin
        mq.delete();
      end else begin
        if (out_fire_m) void'(mq.pop_front());
        if (in_fire_m) mq.push_back(c_in_data);
      end
      chk("rnd_valid", 128'(c_out_valid), 128'(mq.size() != 0));
      chk("rnd_occ", 128'(c_occ), 128'(mq.size()));
      chk("rnd_ready", 128'(c_in_ready), 128'(mq.size() < 2));
      if (mq.size() > 0) chk("rnd_data", 128'(c_out_data), 128'(mq[0]));
      else chk("rnd_bubble_ctrl", 128'(c_out_data[66:64]), 128'(3'd0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
